mult8x8_seq_ctrl: RTL and testbench
===================================

Name: mult8x8_seq_ctrl

Overview:
- Sequential controller that computes an 8x8 unsigned product by scheduling the four 4x4 quadrant partial products through one shared 4x4 partial-product unit, one quadrant per cycle, and accumulating them.
- Each quadrant is selected exact or approximate per operation, so a single slice covers the whole approximate-multiplier family (N2/R2 quadrant mixes) at about a quarter of the multiplier area.
- Sits behind a valid/ready operand interface; result is returned on a valid/ready result interface.

Parameters:
- ACC_W, 17, accumulator width; must be at least 17 so the approximate worst case cannot wrap.
- SAT_EN, 1, 1 = saturate the result to 16'hFFFF when accumulator bit 16 is set; 0 = truncate to the low 16 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  controller can accept an operand; high only in IDLE.
- a  in  8  multiplicand.
- b  in  8  multiplier.
- approx_cfg  in  4  per-quadrant approximate enable: bit0 LL (a[3:0]*b[3:0]), bit1 LH (a[3:0]*b[7:4]), bit2 HL (a[7:4]*b[3:0]), bit3 HH (a[7:4]*b[7:4]).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- r  out  16  product.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset, asynchronous while rst=1: state=IDLE, quadrant counter=0, accumulator=0, captured operands=0. Outputs: in_ready=0 while rst is high, 1 from the first clock after release; out_valid=0; r=0; busy=0.
- Reset mid-operation aborts the operation with no result. The first transaction after reset must be correct.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge T: capture a, b, approx_cfg; clear accumulator; q=0; go to CALC.
- CALC: one quadrant per cycle, q = 0,1,2,3 (LL, LH, HL, HH) on cycles T+1..T+4.
  - Each cycle: acc <= acc + (pp << shift[q]), with shift = 0, 4, 4, 8.
  - pp comes from the partial-product unit for the quadrant nibbles and cfg bit q.
  - At q=3: go to DONE.
- DONE:
  - out_valid=1 from cycle T+5.
  - r = (SAT_EN && acc[16]) ? 16'hFFFF : acc[15:0].
  - r and out_valid are held stable until out_valid && out_ready. On that edge go to IDLE and drop out_valid.
  - An accepted result is followed by in_ready=1 in the next cycle. Throughput is one operation per 6 cycles minimum.
- Latency: the result is presented 5 cycles after the accept edge.
- Operand and cfg pins are ignored outside the accept edge; changes during CALC or DONE have no effect.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored; the requester holds its request.
- Partial-product unit:
  - Exact mode: full 8-bit product of the nibbles.
  - Approximate mode: N2_4x4_mul for q=0..2, R2_4x4_mul for q=3. Outputs are used bit-accurately, unmodified.
- Arithmetic:
  - All values unsigned.
  - The exact sum is at most 65025, so it never saturates.
  - With approximate quadrants the sum is at most 73695, which is why the 17-bit accumulator and saturation exist.
- The accumulator is registered. The partial-product path is combinational within one cycle; no multi-cycle paths.

Decomposition:
- Package mult8_seq_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - quadrant index constants Q_LL=0, Q_LH=1, Q_HL=2, Q_HH=3;
  - shift table {0,4,4,8};
  - SAT_VALUE 16'hFFFF.
- One sub-module, pp4x4_unit: inputs x[3:0], y[3:0], approx, hh_sel; output p[7:0].
  - Instantiates the exact 4x4 product, N2_4x4_mul and R2_4x4_mul, and muxes between them.
  - The FSM, counter, accumulator and handshake stay in the top.

Test Plan:
- cfg=0000, a=8'hFF, b=8'hFF -> r=16'hFE01, out_valid at T+5; in_ready=0 and busy=1 for T+1..T+5.
- cfg=0000, a=8'h12, b=8'h34 -> r=16'h03A8; a=8'h00, b=8'hA7 -> r=16'h0000.
- Backpressure: out_ready=0 for 3 cycles after out_valid -> r and out_valid stable and in_ready=0; on the out_ready=1 edge, out_valid=0 and in_ready=1 on the next cycle.
- Accept a=8'h0F, b=8'hF0, then drive a=8'hAA, b=8'h55 during CALC -> r=16'h0E10, unaffected by the pin changes.
- cfg sweep (0000, 0111, 1000, 1111) with 500 random operand pairs each -> r matches a bit-accurate model of N2/R2 quadrant sums, including the saturation case (result 16'hFFFF when the model sum exceeds 65535, SAT_EN=1).
- Assert rst at q=2 -> out_valid, busy and r are 0 immediately (asynchronously), with no result; after release, a=8'h03, b=8'h05 -> r=16'h000F at T+5.

Source files
------------

// File: rtl/mult8x8_seq_ctrl_pkg.sv
// rtl/mult8x8_seq_ctrl_pkg.sv - shared types and constants for the sequential 8x8 multiplier
// Contents: controller state enum, quadrant indices, per-quadrant shift table,
// saturation value.
package mult8_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quadrant order walked by the controller: LL, LH, HL, HH.
    localparam logic [1:0] Q_LL = 2'd0;
    localparam logic [1:0] Q_LH = 2'd1;
    localparam logic [1:0] Q_HL = 2'd2;
    localparam logic [1:0] Q_HH = 2'd3;

    // Left shift applied to each quadrant's partial product before accumulation.
    localparam logic [3:0] SHIFT_TAB [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

    localparam logic [15:0] SAT_VALUE = 16'hFFFF;

endpackage

// File: rtl/mult8x8_seq_ctrl_if.sv
// rtl/mult8x8_seq_ctrl_if.sv - operand/result handshake bundle for mult8x8_seq_ctrl
// Signals: in_valid/in_ready with a, b, approx_cfg (operand request);
// out_valid/out_ready with r (result); busy (controller occupied).
// master = requester/consumer side, slave = controller side.
interface mult8x8_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  approx_cfg;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r;
    logic        busy;

    modport master (
        output in_valid, a, b, approx_cfg, out_ready,
        input  in_ready, out_valid, r, busy
    );

    modport slave (
        input  in_valid, a, b, approx_cfg, out_ready,
        output in_ready, out_valid, r, busy
    );
endinterface

// File: rtl/mult8x8_seq_ctrl_pp4x4.sv
// rtl/mult8x8_seq_ctrl_pp4x4.sv - shared 4x4 partial-product unit (exact / N2 / R2)
// pp4x4_unit ports: x[3:0], y[3:0] nibbles; approx selects an approximate
// product; hh_sel picks R2 (HH quadrant) over N2 (other quadrants); p[7:0] product.
// Also holds the three leaf multipliers it instantiates.

// Exact nibble product.
module exact_4x4_mul (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    assign p = {4'b0, x} * {4'b0, y};
endmodule

// N2: the two least-significant product bits are not resolved and read as 1.
module N2_4x4_mul (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    logic [7:0] full;
    assign full = {4'b0, x} * {4'b0, y};
    assign p    = {full[7:2], 2'b11};
endmodule

// R2: the low product nibble is not resolved and reads as all ones.
// On 15x15 this gives 8'hEF, which is what lets an HH-approximate sum pass 16 bits.
module R2_4x4_mul (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    logic [7:0] full;
    assign full = {4'b0, x} * {4'b0, y};
    assign p    = {full[7:4], 4'hF};
endmodule

module pp4x4_unit (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       approx,
    input  logic       hh_sel,
    output logic [7:0] p
);
    logic [7:0] p_exact;
    logic [7:0] p_n2;
    logic [7:0] p_r2;

    exact_4x4_mul u_exact (.x(x), .y(y), .p(p_exact));
    N2_4x4_mul    u_n2    (.x(x), .y(y), .p(p_n2));
    R2_4x4_mul    u_r2    (.x(x), .y(y), .p(p_r2));

    always_comb begin
        p = p_exact;
        if (approx) begin
            p = hh_sel ? p_r2 : p_n2;
        end
    end
endmodule

// File: rtl/mult8x8_seq_ctrl.sv
// rtl/mult8x8_seq_ctrl.sv - 8x8 multiplier scheduling four quadrants through one 4x4 unit
// Ports: clk, rst (async, active-high); bus (slave modport): in_valid/in_ready,
// a, b, approx_cfg (bit q = quadrant q approximate), out_valid/out_ready, r, busy.
// Parameters: ACC_W accumulator width (>= 17), SAT_EN clamp to 16'hFFFF on overflow.
module mult8x8_seq_ctrl
    import mult8_seq_pkg::*;
#(
    parameter int ACC_W  = 17,
    parameter int SAT_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    mult8x8_seq_ctrl_if.slave  bus
);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        q;
    logic [ACC_W-1:0]  acc;
    logic [7:0]        a_q;
    logic [7:0]        b_q;
    logic [3:0]        cfg_q;
    logic              run_en;   // keeps in_ready low until the first clock after reset

    logic              accept;
    logic [3:0]        pp_x;
    logic [3:0]        pp_y;
    logic [7:0]        pp;
    logic [ACC_W-1:0]  pp_ext;
    logic              ovf;
    logic [15:0]       result;

    assign accept = bus.in_valid && bus.in_ready;

    // Quadrant q: bit1 picks the high nibble of a, bit0 the high nibble of b.
    assign pp_x = q[1] ? a_q[7:4] : a_q[3:0];
    assign pp_y = q[0] ? b_q[7:4] : b_q[3:0];

    pp4x4_unit u_pp (
        .x      (pp_x),
        .y      (pp_y),
        .approx (cfg_q[q]),
        .hh_sel (q == Q_HH),
        .p      (pp)
    );

    always_comb begin
        pp_ext = ACC_W'(pp) << SHIFT_TAB[q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)        state_nxt = CALC;
            CALC: if (q == Q_HH)     state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q      <= Q_LL;
            acc    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cfg_q  <= '0;
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        cfg_q <= bus.approx_cfg;
                        acc   <= '0;
                        q     <= Q_LL;
                    end
                end
                CALC: begin
                    acc <= acc + pp_ext;
                    q   <= q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Anything at or above bit 16 means the 16-bit result has wrapped.
    assign ovf    = |acc[ACC_W-1:16];
    assign result = ((SAT_EN != 0) && ovf) ? SAT_VALUE : acc[15:0];

    always_comb begin
        bus.in_ready  = (state == IDLE) && run_en;
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.r         = (state == DONE) ? result : 16'h0000;
    end

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// tb/tb_mult8x8_seq_ctrl.sv - self-checking bench for mult8x8_seq_ctrl
module tb_mult8x8_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult8x8_seq_ctrl_if bus ();

    mult8x8_seq_ctrl #(.ACC_W(17), .SAT_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  cfg;
        logic [15:0] r;
        int          hold;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pp_model(input logic [3:0] x, input logic [3:0] y,
                                            input logic ap, input logic hh);
        int e;
        e = int'(x) * int'(y);
        if (!ap) return 8'(e);
        if (hh)  return 8'((e / 16) * 16 + 15);
        return 8'((e / 4) * 4 + 3);
    endfunction

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] c);
        int s;
        s = int'(pp_model(a[3:0], b[3:0], c[0], 1'b0))
          + int'(pp_model(a[3:0], b[7:4], c[1], 1'b0)) * 16
          + int'(pp_model(a[7:4], b[3:0], c[2], 1'b0)) * 16
          + int'(pp_model(a[7:4], b[7:4], c[3], 1'b1)) * 256;
        if (s > 65535) return 16'hFFFF;
        return s[15:0];
    endfunction

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] tc,
                          input logic [15:0] exp, input int hold, input string nm);
        int k;
        logic [15:0] r0;
        exp_q.push_back(exp);
        @(negedge clk);
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({nm, " in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid   = 1'b1;
        bus.a          = ta;
        bus.b          = tb_;
        bus.approx_cfg = tc;
        @(posedge clk);
        #1;
        // Operand pins change right after the accept edge and must be ignored.
        bus.in_valid   = 1'b0;
        bus.a          = ta ^ 8'hA5;
        bus.b          = tb_ ^ 8'hA5;
        bus.approx_cfg = ~tc;
        @(negedge clk);
        k = 0;
        while (!bus.out_valid && k < 10) begin
            check({nm, " busy_calc"}, 32'(bus.busy), 32'd1);
            check({nm, " in_ready_calc"}, 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            k++;
        end
        check({nm, " latency"}, 32'(k), 32'd4);
        if (!bus.out_valid) begin
            check({nm, " out_valid_timeout"}, 32'(bus.out_valid), 32'd1);
            void'(exp_q.pop_front());
            return;
        end
        check({nm, " busy_done"}, 32'(bus.busy), 32'd1);
        r0 = bus.r;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({nm, " hold_r"}, 32'(bus.r), 32'(r0));
            check({nm, " hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({nm, " hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        check({nm, " r"}, 32'(bus.r), 32'(exp_q.pop_front()));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({nm, " out_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({nm, " in_ready_after"}, 32'(bus.in_ready), 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [3:0] cfgs [4];

        vecs.push_back('{8'hFF, 8'hFF, 4'b0000, 16'hFE01, 0});
        vecs.push_back('{8'h12, 8'h34, 4'b0000, 16'h03A8, 3});
        vecs.push_back('{8'h00, 8'hA7, 4'b0000, 16'h0000, 0});
        vecs.push_back('{8'h0F, 8'hF0, 4'b0000, 16'h0E10, 1});
        vecs.push_back('{8'hFF, 8'hFF, 4'b0111, 16'hFE43, 0});
        vecs.push_back('{8'h01, 8'h01, 4'b1000, 16'h0F01, 0});
        vecs.push_back('{8'hFF, 8'hFF, 4'b1111, 16'hFFFF, 2});

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.a          = 8'h00;
        bus.b          = 8'h00;
        bus.approx_cfg = 4'h0;
        bus.out_ready  = 1'b0;
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset r", 32'(bus.r), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        check("reset in_ready_held", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cfg, vecs[i].r, vecs[i].hold,
                   $sformatf("vec%0d", i));
        end

        cfgs = '{4'b0000, 4'b0111, 4'b1000, 4'b1111};
        for (int c = 0; c < 4; c++) begin
            for (int n = 0; n < 500; n++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                if (n == 0) begin
                    ra = 8'hFF;
                    rb = 8'hFF;
                end
                run_op(ra, rb, cfgs[c], model(ra, rb, cfgs[c]), 0,
                       $sformatf("rnd cfg%0d n%0d", c, n));
            end
        end

        // Reset during the HL quadrant aborts the operation.
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.a          = 8'hFF;
        bus.b          = 8'hFF;
        bus.approx_cfg = 4'h0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort r", 32'(bus.r), 32'd0);
        check("abort in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort in_ready_after", 32'(bus.in_ready), 32'd1);
        check("abort no_result", 32'(bus.out_valid), 32'd0);
        run_op(8'h03, 8'h05, 4'b0000, 16'h000F, 0, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
